// File: rtl/conv25_dot_calc.sv
// conv25_dot_calc: 25-tap signed fixed-point dot product plus bias.
// Fixed 7-clock latency, one bundle per cycle, saturating output.
module conv25_dot_add #(
  parameter int ACC = 37,
  parameter int N   = 2,
  parameter int M   = (N + 1) / 2
) (
  input  logic                   clk,
  input  logic [N-1:0][ACC-1:0]  i_t,
  output logic [M-1:0][ACC-1:0]  o_t
);

  logic [M-1:0][ACC-1:0] w_t;

  // Odd leftover term is passed through unchanged.
  for (genvar g = 0; g < M; g++) begin : g_term
    if (2*g + 1 < N) begin : g_add
      assign w_t[g] = i_t[2*g] + i_t[2*g+1];
    end else begin : g_pass
      assign w_t[g] = i_t[2*g];
    end
  end

  always_ff @(posedge clk) begin
    o_t <= w_t;
  end

endmodule

module conv25_dot_calc #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int TAPS  = 25,
  parameter int RELU  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic [(2*TAPS+1)*WIDTH-1:0]     data_from_ctrl_i,
  output logic [WIDTH-1:0]                data_to_ctrl_o,
  output logic                            valid_o,
  output logic                            sat_o,
  output logic                            busy_o
);

  localparam int PW  = 2 * WIDTH;
  localparam int ACC = 2 * WIDTH + 5;
  localparam int N2  = TAPS + 1;
  localparam int N3  = (N2 + 1) / 2;
  localparam int N4  = (N3 + 1) / 2;
  localparam int N5  = (N4 + 1) / 2;
  localparam int N6  = (N5 + 1) / 2;
  localparam int KO  = (TAPS + 1) * WIDTH;

  logic [7:1]                  r_v;
  logic [TAPS-1:0][WIDTH-1:0]  r_k;
  logic [TAPS-1:0][WIDTH-1:0]  r_d;
  logic [WIDTH-1:0]            r_b;
  logic [TAPS-1:0][PW-1:0]     w_p;
  logic [N2-1:0][ACC-1:0]      r_s2;
  logic [N3-1:0][ACC-1:0]      r_s3;
  logic [N4-1:0][ACC-1:0]      r_s4;
  logic [N5-1:0][ACC-1:0]      r_s5;
  logic [N6-1:0][ACC-1:0]      r_s6;
  logic [0:0][ACC-1:0]         r_s7;
  logic signed [ACC-1:0]       w_sum;
  logic signed [ACC-1:0]       w_shr;
  logic                        w_ovf;
  logic                        w_unf;
  logic [WIDTH-1:0]            w_sat;
  logic [WIDTH-1:0]            w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[6:1], valid_i};
    end
  end

  assign busy_o = |r_v[6:1];

  always_ff @(posedge clk) begin
    if (valid_i) begin
      for (int i = 0; i < TAPS; i++) begin
        r_d[i] <= data_from_ctrl_i[WIDTH + WIDTH*i +: WIDTH];
        r_k[i] <= data_from_ctrl_i[KO + WIDTH*i +: WIDTH];
      end
      r_b <= data_from_ctrl_i[WIDTH-1:0];
    end
  end

  // Sign-extended operands: the low PW bits are the exact signed product.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_p[i] = {{WIDTH{r_k[i][WIDTH-1]}}, r_k[i]}
             * {{WIDTH{r_d[i][WIDTH-1]}}, r_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TAPS; i++) begin
      r_s2[i] <= {{(ACC-PW){w_p[i][PW-1]}}, w_p[i]};
    end
    r_s2[TAPS] <= {{(ACC-WIDTH-FRAC){r_b[WIDTH-1]}},
                   r_b, {FRAC{1'b0}}};
  end

  conv25_dot_add #(.ACC(ACC), .N(N2)) u_s3 (
    .clk (clk), .i_t (r_s2), .o_t (r_s3)
  );
  conv25_dot_add #(.ACC(ACC), .N(N3)) u_s4 (
    .clk (clk), .i_t (r_s3), .o_t (r_s4)
  );
  conv25_dot_add #(.ACC(ACC), .N(N4)) u_s5 (
    .clk (clk), .i_t (r_s4), .o_t (r_s5)
  );
  conv25_dot_add #(.ACC(ACC), .N(N5)) u_s6 (
    .clk (clk), .i_t (r_s5), .o_t (r_s6)
  );
  conv25_dot_add #(.ACC(ACC), .N(N6)) u_s7 (
    .clk (clk), .i_t (r_s6), .o_t (r_s7)
  );

  assign w_sum = r_s7[0];
  assign w_shr = w_sum >>> FRAC;
  assign w_ovf = !w_shr[ACC-1] && (|w_shr[ACC-2:WIDTH-1]);
  assign w_unf = w_shr[ACC-1] && !(&w_shr[ACC-2:WIDTH-1]);

  always_comb begin
    w_sat = w_shr[WIDTH-1:0];
    unique case (1'b1)
      w_ovf:   w_sat = {1'b0, {(WIDTH-1){1'b1}}};
      w_unf:   w_sat = {1'b1, {(WIDTH-1){1'b0}}};
      default: w_sat = w_shr[WIDTH-1:0];
    endcase
  end

  assign w_res = (RELU != 0 && w_sat[WIDTH-1]) ? '0 : w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_to_ctrl_o <= '0;
      valid_o        <= 1'b0;
      sat_o          <= 1'b0;
    end else begin
      valid_o <= r_v[7];
      sat_o   <= r_v[7] & (w_ovf | w_unf);
      if (r_v[7]) begin
        data_to_ctrl_o <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_conv25_dot_calc.sv
// tb_conv25_dot_calc: random and directed bundles vs. arithmetic model.
// Two instances cover RELU=0 and RELU=1 on the same stimulus.
module tb_conv25_dot_calc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic [815:0] din;
  logic [15:0]  d0, d1;
  logic         v0, v1, s0, s1, b0, b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int kv[25];
  int dv[25];
  int bv;
  int last0 = 0;
  int last1 = 0;

  typedef struct {
    int due;
    int r0;
    int r1;
    bit sat;
  } exp_t;

  exp_t q[$];
  int   iss[$];

  always #5 clk = ~clk;

  conv25_dot_calc #(.RELU(0)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .valid_i (valid_i),
    .data_from_ctrl_i (din), .data_to_ctrl_o (d0),
    .valid_o (v0), .sat_o (s0), .busy_o (b0)
  );

  conv25_dot_calc #(.RELU(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .valid_i (valid_i),
    .data_from_ctrl_i (din), .data_to_ctrl_o (d1),
    .valid_o (v1), .sat_o (s1), .busy_o (b1)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  // Q8.8 dot product: exact sum, floor shift, clamp, then optional ReLU.
  function automatic exp_t ref_calc(input int due);
    exp_t   e;
    longint acc;
    longint sh;
    acc = longint'(bv) * 256;
    for (int i = 0; i < 25; i++) acc += longint'(kv[i]) * longint'(dv[i]);
    sh = acc >>> 8;
    e.due = due;
    e.sat = 1'b0;
    if (sh > 32767) begin
      e.r0 = 32767; e.sat = 1'b1;
    end else if (sh < -32768) begin
      e.r0 = -32768; e.sat = 1'b1;
    end else begin
      e.r0 = int'(sh);
    end
    e.r1 = (e.r0 < 0) ? 0 : e.r0;
    return e;
  endfunction

  task automatic pack();
    for (int i = 0; i < 25; i++) begin
      din[16 + 16*i +: 16]  = 16'(dv[i]);
      din[416 + 16*i +: 16] = 16'(kv[i]);
    end
    din[15:0] = 16'(bv);
  endtask

  task automatic fill(input int k, input int d, input int b);
    for (int i = 0; i < 25; i++) begin
      kv[i] = k;
      dv[i] = d;
    end
    bv = b;
  endtask

  task automatic check_cycle();
    bit   ev;
    bit   busy;
    exp_t e;
    while (iss.size() > 0 && iss[0] < cyc - 5) void'(iss.pop_front());
    busy = (iss.size() > 0);
    ev   = (q.size() > 0 && q[0].due == cyc);
    chk("valid0", 16'(v0), 16'(ev));
    chk("valid1", 16'(v1), 16'(ev));
    chk("busy", 16'(b0), 16'(busy));
    if (ev) begin
      e = q.pop_front();
      chk("data0", d0, 16'(e.r0));
      chk("data1", d1, 16'(e.r1));
      chk("sat0", 16'(s0), 16'(e.sat));
      chk("sat1", 16'(s1), 16'(e.sat));
      last0 = e.r0;
      last1 = e.r1;
    end else begin
      chk("sat_idle", 16'(s0), 16'(0));
      chk("hold0", d0, 16'(last0));
      chk("hold1", d1, 16'(last1));
    end
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n && valid_i) begin
      q.push_back(ref_calc(cyc + 7));
      iss.push_back(cyc);
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic send(input bit v);
    valid_i = v;
    pack();
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask

  task automatic rnd_bundle();
    logic signed [15:0] t;
    bit full;
    full = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 25; i++) begin
      t = full ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      kv[i] = int'(t);
      t = full ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      dv[i] = int'(t);
    end
    t = 16'($urandom);
    bv = int'(t);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    fill(0, 0, 0);
    pack();
    idle(3);
    rst_n = 1'b1;
    idle(2);

    fill(256, 256, 0);
    send(1'b1);
    idle(9);

    fill(0, 77, -256);
    send(1'b1);
    idle(9);

    fill(32767, 32767, 0);
    send(1'b1);
    fill(32767, -32768, 0);
    send(1'b1);
    idle(9);

    fill(0, 0, 0);
    kv[0] = 1; dv[0] = 128;
    send(1'b1);
    kv[0] = -1;
    send(1'b1);
    idle(9);

    fill(0, 0, 0);
    kv[3] = 256;
    for (int n = 1; n <= 10; n++) begin
      dv[3] = 256 * n;
      send(1'b1);
    end
    idle(2);
    for (int n = 11; n <= 13; n++) begin
      dv[3] = 256 * n;
      send(1'b1);
    end
    idle(9);

    fill(100, 200, 50);
    send(1'b1);
    send(1'b1);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_data0", d0, 16'(0));
    chk("rst_valid0", 16'(v0), 16'(0));
    chk("rst_busy", 16'(b0), 16'(0));
    q.delete();
    iss.delete();
    last0 = 0;
    last1 = 0;
    rnd_bundle();
    send(1'b1);
    send(1'b1);
    rst_n = 1'b1;
    fill(0, 0, 0);
    kv[7] = 512; dv[7] = -384; bv = 300;
    send(1'b1);
    idle(9);

    for (int i = 0; i < 300; i++) begin
      rnd_bundle();
      send($urandom_range(0, 3) != 0);
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv25_dot_calc.md
Name: conv25_dot_calc

Overview:
- Pipelined compute responder for the CNN layer controllers (dense/conv layers).
- Accepts one packed operand bundle per cycle on data_from_ctrl_i: 25 kernel weights, 25 window samples and one bias.
- Returns one 16-bit fixed-point result: the saturated dot product plus bias, with optional ReLU.
- Latency is exactly 7 clocks, so the controller's valid-delay shift chain lines up. No back-pressure.

Parameters:
WIDTH, 16, operand/result word width (signed two's complement)
FRAC, 8, fractional bits of the Q(WIDTH-FRAC).FRAC format
TAPS, 25, dot-product length (fixed at 25 for this revision; any other value is unsupported)
RELU, 0, 1 = clamp negative results to 0 after saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
valid_i  in  1  operand bundle on data_from_ctrl_i is valid this cycle
data_from_ctrl_i  in  816  {kernel[24..0], data[24..0], bias}; bias=[15:0], data[i]=[16+16*i +:16], kernel[i]=[416+16*i +:16]
data_to_ctrl_o  out  16  result word
valid_o  out  1  one-cycle strobe, data_to_ctrl_o valid
sat_o  out  1  one-cycle strobe coincident with valid_o when the result saturated
busy_o  out  1  OR of all pipeline-stage valid bits (results in flight)

Behaviour:
- Reset (async assert, sync release): all stage valid bits, valid_o, sat_o and busy_o go to 0; data_to_ctrl_o = 0. Pipeline data registers need no reset.
- Throughput: one bundle per cycle, unconditionally accepted. Results emerge in issue order. No stalls, no drops.
- Latency: bundle sampled with valid_i=1 at edge k gives valid_o=1 from edge k+7 for exactly one cycle.
- Stages:
  - S1 (edge k): capture the bundle.
  - S2: 25 signed WIDTHxWIDTH multiplies giving 2*WIDTH-bit products. Bias is sign-extended and shifted left by FRAC to product scale as term 26.
  - S3: 26→13 pairwise add.
  - S4: 13→7.
  - S5: 7→4.
  - S6: 4→2. Odd leftover terms pass through registered.
  - S7: final add, arithmetic shift right by FRAC, saturate, optional ReLU, register outputs.
- Accumulator width: 2*WIDTH+5 = 37 bits signed. No intermediate overflow is possible.
- Rounding: truncation toward −inf (plain arithmetic shift), no rounding bias.
- Saturation: shifted sum > 2^(WIDTH-1)−1 gives 0x7FFF; < −2^(WIDTH-1) gives 0x8000. sat_o=1 in either case.
- ReLU: applied after saturation. With RELU=1, 0x8000 saturation yields 0x0000 and sat_o is still 1.
- data_to_ctrl_o holds its last value when valid_o=0. It is only meaningful when valid_o=1.
- Each stage carries a valid bit. Invalid bubbles propagate and never produce valid_o.
- busy_o is high whenever any of the S1..S6 valid bits is set.
- Reset mid-operation: all in-flight bundles are discarded. No valid_o occurs for any bundle sampled before rst_n fell, even after release.
- valid_i asserted during reset is ignored.
- X on data_from_ctrl_i while valid_i=0 must not propagate to valid_o or sat_o.

Test Plan:
1. All kernel=0x0100, data=0x0100, bias=0x0000, one valid_i pulse at edge k -> valid_o at k+7 only, data_to_ctrl_o=0x1900, sat_o=0, busy_o high k+1..k+6.
2. kernel=0, bias=0xFF00 (−1.0) -> RELU=0: 0xFF00; RELU=1: 0x0000; sat_o=0 in both.
3. All kernel=0x7FFF, data=0x7FFF -> 0x7FFF with sat_o=1. All kernel=0x7FFF, data=0x8000 -> 0x8000 with sat_o=1 (RELU=0).
4. Truncation: kernel[0]=0x0001, data[0]=0x0080, rest 0, bias 0 -> 0x0000. Then kernel[0]=0xFFFF with same data -> 0xFFFF (−1 LSB).
5. 10 back-to-back bundles, data[3]=0x0100*n, kernel[3]=0x0100, rest 0, n=1..10 -> valid_o high 10 consecutive cycles from k+7, results 0x0100..0x0A00 in order. A 2-cycle gap in valid_i appears as the same gap in valid_o.
6. valid_i at k and k+1, rst_n low at k+3 for 2 cycles -> valid_o never asserts, data_to_ctrl_o=0 immediately on reset assertion. A new bundle at release+1 returns correctly 7 edges later.
